// File: rtl/fst_pkg.sv
// Shared widths and the lock-table entry type for the core/memory interconnect.
package fst_pkg;

    localparam int unsigned N_LOCK  = 16;
    localparam int unsigned LOCK_W  = 4;
    localparam int unsigned ADR_W   = 16;
    localparam int unsigned DAT_W   = 16;
    localparam int unsigned OWNER_W = 3;

    typedef struct packed {
        logic               held;
        logic [OWNER_W-1:0] owner;
    } lock_entry_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at C.
module rr_pick #(
    parameter  int unsigned C  = 8,
    localparam int unsigned PW = (C > 1) ? $clog2(C) : 1
) (
    input  logic [C-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          valid_o,
    output logic [PW-1:0] idx_o,
    output logic [C-1:0]  onehot_o
);

    int unsigned j;

    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        j        = 0;
        for (int unsigned k = 0; k < C; k++) begin
            // Explicit wrap so C need not be a power of two.
            j = 32'(ptr_i) + k;
            if (j >= C) j = j - C;
            if (!valid_o && req_i[PW'(j)]) begin
                valid_o            = 1'b1;
                idx_o              = PW'(j);
                onehot_o[PW'(j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Round-robin arbiter for the shared main_mem port plus a spin-lock table shared by C cores.
module mem_lock_arbiter
    import fst_pkg::*;
#(
    parameter int unsigned C      = 8,
    parameter int unsigned N_LOCK = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [C-1:0]             rd_req,
    input  logic [C-1:0]             wr_req,
    input  logic [C-1:0][ADR_W-1:0]  rd_adr,
    input  logic [C-1:0][ADR_W-1:0]  wr_adr,
    input  logic [C-1:0][DAT_W-1:0]  wr_dat,
    input  logic [C-1:0]             lock_en,
    input  logic [C-1:0]             unlock_en,
    input  logic [C-1:0][LOCK_W-1:0] lock_adr,
    output logic [C-1:0]             main_mem_ac,
    output logic [C-1:0]             lock_ac,
    output logic [ADR_W-1:0]         mem_adr,
    output logic [DAT_W-1:0]         mem_wdat,
    output logic                     mem_we
);

    localparam int unsigned PW = (C > 1) ? $clog2(C) : 1;

    logic [C-1:0]     main_mem_ac_q, main_mem_ac_d;
    logic [C-1:0]     lock_ac_q, lock_ac_d;
    logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
    logic [DAT_W-1:0] mem_wdat_q, mem_wdat_d;
    logic             mem_we_q, mem_we_d;
    logic [PW-1:0]    mem_ptr_q, mem_ptr_d;
    logic [PW-1:0]    lock_ptr_q, lock_ptr_d;
    lock_entry_t      lock_q [N_LOCK];
    lock_entry_t      lock_d [N_LOCK];

    logic [C-1:0]     mem_req, lock_cand;
    logic             mem_vld, lock_vld;
    logic [PW-1:0]    mem_idx, lock_idx;
    logic [C-1:0]     mem_oh, lock_oh;

    // The core whose grant is visible this cycle still shows its stale request.
    assign mem_req = (rd_req | wr_req) & ~main_mem_ac_q;

    always_comb begin
        lock_cand = '0;
        for (int unsigned i = 0; i < C; i++) begin
            lock_cand[PW'(i)] = lock_en[PW'(i)] &
                                (!lock_q[lock_adr[PW'(i)]].held |
                                 (lock_q[lock_adr[PW'(i)]].owner == OWNER_W'(i)));
        end
    end

    rr_pick #(.C(C)) u_mem_pick (
        .req_i    (mem_req),
        .ptr_i    (mem_ptr_q),
        .valid_o  (mem_vld),
        .idx_o    (mem_idx),
        .onehot_o (mem_oh)
    );

    rr_pick #(.C(C)) u_lock_pick (
        .req_i    (lock_cand),
        .ptr_i    (lock_ptr_q),
        .valid_o  (lock_vld),
        .idx_o    (lock_idx),
        .onehot_o (lock_oh)
    );

    always_comb begin
        main_mem_ac_d = mem_oh;
        mem_adr_d     = '0;
        mem_wdat_d    = '0;
        mem_we_d      = 1'b0;
        mem_ptr_d     = mem_ptr_q;
        if (mem_vld) begin
            if (wr_req[mem_idx]) begin
                mem_we_d   = 1'b1;
                mem_adr_d  = wr_adr[mem_idx];
                mem_wdat_d = wr_dat[mem_idx];
            end else begin
                mem_adr_d  = rd_adr[mem_idx];
            end
            mem_ptr_d = (mem_idx == PW'(C - 1)) ? '0 : mem_idx + 1'b1;
        end

        // Releases and the acquire both decide on lock_q; the acquire write lands last.
        lock_d = lock_q;
        for (int unsigned i = 0; i < C; i++) begin
            if (unlock_en[PW'(i)] && lock_q[lock_adr[PW'(i)]].held &&
                (lock_q[lock_adr[PW'(i)]].owner == OWNER_W'(i))) begin
                lock_d[lock_adr[PW'(i)]].held = 1'b0;
            end
        end
        lock_ac_d  = lock_oh;
        lock_ptr_d = lock_ptr_q;
        if (lock_vld) begin
            lock_d[lock_adr[lock_idx]] = '{held: 1'b1, owner: OWNER_W'(lock_idx)};
            lock_ptr_d = (lock_idx == PW'(C - 1)) ? '0 : lock_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_mem_ac_q <= '0;
            lock_ac_q     <= '0;
            mem_adr_q     <= '0;
            mem_wdat_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_ptr_q     <= '0;
            lock_ptr_q    <= '0;
            lock_q        <= '{default: '0};
        end else begin
            main_mem_ac_q <= main_mem_ac_d;
            lock_ac_q     <= lock_ac_d;
            mem_adr_q     <= mem_adr_d;
            mem_wdat_q    <= mem_wdat_d;
            mem_we_q      <= mem_we_d;
            mem_ptr_q     <= mem_ptr_d;
            lock_ptr_q    <= lock_ptr_d;
            lock_q        <= lock_d;
        end
    end

    assign main_mem_ac = main_mem_ac_q;
    assign lock_ac     = lock_ac_q;
    assign mem_adr     = mem_adr_q;
    assign mem_wdat    = mem_wdat_q;
    assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level model of mem_lock_arbiter.
module tb_mem_lock_arbiter;

    localparam int C = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       rd_req, wr_req, lock_en, unlock_en;
    logic [7:0][15:0] rd_adr, wr_adr, wr_dat;
    logic [7:0][3:0]  lock_adr;
    logic [7:0]       main_mem_ac, lock_ac;
    logic [15:0]      mem_adr, mem_wdat;
    logic             mem_we;

    int checks = 0;
    int errors = 0;

    // Model state: pointers, last memory winner, lock table.
    int         m_ptr, m_last, l_ptr;
    bit         m_held [16];
    int         m_owner [16];
    logic [7:0]  e_mac, e_lac;
    logic [15:0] e_adr, e_dat;
    logic        e_we;

    always #5 clk = ~clk;

    mem_lock_arbiter #(.C(8), .N_LOCK(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .rd_adr      (rd_adr),
        .wr_adr      (wr_adr),
        .wr_dat      (wr_dat),
        .lock_en     (lock_en),
        .unlock_en   (unlock_en),
        .lock_adr    (lock_adr),
        .main_mem_ac (main_mem_ac),
        .lock_ac     (lock_ac),
        .mem_adr     (mem_adr),
        .mem_wdat    (mem_wdat),
        .mem_we      (mem_we)
    );

    task automatic model_reset();
        m_ptr = 0; m_last = -1; l_ptr = 0;
        for (int k = 0; k < 16; k++) begin
            m_held[4'(k)] = 1'b0;
            m_owner[4'(k)] = 0;
        end
        e_mac = '0; e_lac = '0; e_adr = '0; e_dat = '0; e_we = 1'b0;
    endtask

    task automatic clear_inputs();
        rd_req = '0; wr_req = '0; lock_en = '0; unlock_en = '0;
        rd_adr = '0; wr_adr = '0; wr_dat = '0; lock_adr = '0;
    endtask

    // Predict from the inputs present now, advance one clock, commit the prediction.
    task automatic cycle();
        int w, lw;
        logic [2:0] c;
        logic [3:0] a, la;
        bit rel [16];
        logic [7:0] n_mac, n_lac;
        logic [15:0] n_adr, n_dat;
        logic n_we;
        w = -1; lw = -1; la = '0;
        for (int k = 0; k < C; k++) begin
            c = 3'((m_ptr + k) % C);
            if (w < 0 && int'(c) != m_last && (rd_req[c] || wr_req[c])) w = int'(c);
        end
        for (int k = 0; k < C; k++) begin
            c = 3'((l_ptr + k) % C);
            a = lock_adr[c];
            if (lw < 0 && lock_en[c] && (!m_held[a] || m_owner[a] == int'(c))) begin
                lw = int'(c);
                la = a;
            end
        end
        for (int k = 0; k < 16; k++) rel[4'(k)] = 1'b0;
        for (int k = 0; k < C; k++) begin
            c = 3'(k);
            a = lock_adr[c];
            if (unlock_en[c] && m_held[a] && m_owner[a] == k) rel[a] = 1'b1;
        end
        n_mac = '0; n_adr = '0; n_dat = '0; n_we = 1'b0;
        if (w >= 0) begin
            c = 3'(w);
            n_mac = 8'(1 << w);
            n_we  = wr_req[c];
            n_adr = wr_req[c] ? wr_adr[c] : rd_adr[c];
            n_dat = wr_dat[c];
        end
        n_lac = (lw >= 0) ? 8'(1 << lw) : 8'h00;
        @(posedge clk);
        #1;
        m_last = w;
        if (w >= 0) m_ptr = (w + 1) % C;
        for (int k = 0; k < 16; k++) if (rel[4'(k)]) m_held[4'(k)] = 1'b0;
        if (lw >= 0) begin
            m_held[la] = 1'b1;
            m_owner[la] = lw;
            l_ptr = (lw + 1) % C;
        end
        e_mac = n_mac; e_lac = n_lac; e_adr = n_adr; e_dat = n_dat; e_we = n_we;
    endtask

    task automatic test_reset();
        logic [7:0] exp_ac;
        clear_inputs();
        reset = 1'b1;
        rd_req = 8'hFF;
        for (int i = 0; i < C; i++) rd_adr[3'(i)] = 16'h1000 + 16'(i);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (main_mem_ac !== 8'h00) begin errors++; $display("FAIL rst_mac: got %h expected 00", main_mem_ac); end
        checks++; if (lock_ac !== 8'h00) begin errors++; $display("FAIL rst_lac: got %h expected 00", lock_ac); end
        checks++; if ({mem_adr, mem_wdat, mem_we} !== 33'h0) begin errors++; $display("FAIL rst_bus: got %h/%h/%b expected 0", mem_adr, mem_wdat, mem_we); end
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 9; k++) begin
            cycle();
            exp_ac = 8'(1 << (k % 8));
            checks++; if (main_mem_ac !== exp_ac) begin errors++; $display("FAIL rr_ac[%0d]: got %h expected %h", k, main_mem_ac, exp_ac); end
            checks++; if (mem_adr !== 16'h1000 + 16'(k % 8)) begin errors++; $display("FAIL rr_adr[%0d]: got %h expected %h", k, mem_adr, 16'h1000 + 16'(k % 8)); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rr_we[%0d]: got %b expected 0", k, mem_we); end
        end
        rd_req = '0;
        cycle();
        checks++; if ({main_mem_ac, mem_adr, mem_we} !== 25'h0) begin errors++; $display("FAIL idle_out: got %h/%h/%b expected 0", main_mem_ac, mem_adr, mem_we); end
    endtask

    task automatic test_write();
        clear_inputs();
        cycle();
        wr_req[3] = 1'b1; wr_adr[3] = 16'h0040; wr_dat[3] = 16'hBEEF; rd_adr[3] = 16'h1234;
        cycle();
        checks++; if (main_mem_ac !== 8'h08) begin errors++; $display("FAIL wr_ac: got %h expected 08", main_mem_ac); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b expected 1", mem_we); end
        checks++; if (mem_adr !== 16'h0040) begin errors++; $display("FAIL wr_adr: got %h expected 0040", mem_adr); end
        checks++; if (mem_wdat !== 16'hBEEF) begin errors++; $display("FAIL wr_dat: got %h expected BEEF", mem_wdat); end
        wr_req[3] = 1'b0;
        rd_req[6] = 1'b1; rd_adr[6] = 16'h0ABC; wr_adr[6] = 16'h7777;
        cycle();
        checks++; if (main_mem_ac !== 8'h40) begin errors++; $display("FAIL rd_ac: got %h expected 40", main_mem_ac); end
        checks++; if ({mem_adr, mem_we} !== {16'h0ABC, 1'b0}) begin errors++; $display("FAIL rd_bus: got %h/%b expected 0abc/0", mem_adr, mem_we); end
        clear_inputs();
        cycle();
    endtask

    task automatic test_lock_contend();
        clear_inputs();
        lock_en[1] = 1'b1; lock_adr[1] = 4'h2;
        lock_en[5] = 1'b1; lock_adr[5] = 4'h2;
        cycle();
        checks++; if (lock_ac !== 8'h02) begin errors++; $display("FAIL lk_first: got %h expected 02", lock_ac); end
        lock_en[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (lock_ac !== 8'h00) begin errors++; $display("FAIL lk_wait[%0d]: got %h expected 00", k, lock_ac); end
        end
        unlock_en[1] = 1'b1;
        cycle();
        checks++; if (lock_ac !== 8'h00) begin errors++; $display("FAIL lk_early: got %h expected 00", lock_ac); end
        unlock_en[1] = 1'b0;
        cycle();
        checks++; if (lock_ac !== 8'h20) begin errors++; $display("FAIL lk_handoff: got %h expected 20", lock_ac); end
        lock_en[5] = 1'b0; unlock_en[5] = 1'b1;
        cycle();
        clear_inputs();
        cycle();
    endtask

    task automatic test_nonowner();
        clear_inputs();
        lock_en[2] = 1'b1; lock_adr[2] = 4'h7;
        cycle();
        checks++; if (lock_ac !== 8'h04) begin errors++; $display("FAIL no_take: got %h expected 04", lock_ac); end
        lock_en[2] = 1'b0;
        unlock_en[4] = 1'b1; lock_adr[4] = 4'h7;
        lock_en[6] = 1'b1; lock_adr[6] = 4'h7;
        cycle();
        unlock_en[4] = 1'b0;
        checks++; if (lock_ac !== 8'h00) begin errors++; $display("FAIL no_same: got %h expected 00", lock_ac); end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (lock_ac !== 8'h00) begin errors++; $display("FAIL no_denied[%0d]: got %h expected 00", k, lock_ac); end
        end
        unlock_en[2] = 1'b1;
        cycle();
        unlock_en[2] = 1'b0;
        checks++; if (lock_ac !== 8'h00) begin errors++; $display("FAIL no_rel: got %h expected 00", lock_ac); end
        cycle();
        checks++; if (lock_ac !== 8'h40) begin errors++; $display("FAIL no_grant: got %h expected 40", lock_ac); end
        lock_en[6] = 1'b0; unlock_en[6] = 1'b1;
        cycle();
        clear_inputs();
        cycle();
    endtask

    task automatic test_same_cycle();
        clear_inputs();
        lock_en[0] = 1'b1; lock_adr[0] = 4'h3;
        cycle();
        checks++; if (lock_ac !== 8'h01) begin errors++; $display("FAIL sc_take: got %h expected 01", lock_ac); end
        lock_en[0] = 1'b0; unlock_en[0] = 1'b1;
        lock_en[1] = 1'b1; lock_adr[1] = 4'h3;
        cycle();
        unlock_en[0] = 1'b0;
        checks++; if (lock_ac !== 8'h00) begin errors++; $display("FAIL sc_same: got %h expected 00", lock_ac); end
        cycle();
        checks++; if (lock_ac !== 8'h02) begin errors++; $display("FAIL sc_next: got %h expected 02", lock_ac); end
        lock_en[1] = 1'b0; unlock_en[1] = 1'b1;
        cycle();
        clear_inputs();
        cycle();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        lock_en[2] = 1'b1; lock_adr[2] = 4'h9;
        cycle();
        checks++; if (lock_ac !== 8'h04) begin errors++; $display("FAIL rm_take: got %h expected 04", lock_ac); end
        lock_en[2] = 1'b0;
        rd_req[5] = 1'b1; rd_adr[5] = 16'h0055;
        cycle();
        checks++; if ({main_mem_ac, mem_adr} !== {8'h20, 16'h0055}) begin errors++; $display("FAIL rm_pend: got %h/%h expected 20/0055", main_mem_ac, mem_adr); end
        reset = 1'b1;
        #1;
        checks++; if ({main_mem_ac, lock_ac, mem_adr, mem_wdat, mem_we} !== 49'h0) begin errors++; $display("FAIL rm_async: got %h/%h/%h/%h/%b expected 0", main_mem_ac, lock_ac, mem_adr, mem_wdat, mem_we); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        lock_en[4] = 1'b1; lock_adr[4] = 4'h9;
        cycle();
        checks++; if (lock_ac !== 8'h10) begin errors++; $display("FAIL rm_after: got %h expected 10", lock_ac); end
        checks++; if (main_mem_ac !== 8'h00) begin errors++; $display("FAIL rm_nomem: got %h expected 00", main_mem_ac); end
        lock_en[4] = 1'b0; unlock_en[4] = 1'b1;
        cycle();
        clear_inputs();
        cycle();
    endtask

    task automatic test_random();
        logic [2:0] c;
        logic [3:0] a;
        int r;
        clear_inputs();
        cycle();
        for (int n = 0; n < 400; n++) begin
            cycle();
            checks++; if (main_mem_ac !== e_mac) begin errors++; $display("FAIL rnd_mac[%0d]: got %h expected %h", n, main_mem_ac, e_mac); end
            checks++; if (lock_ac !== e_lac) begin errors++; $display("FAIL rnd_lac[%0d]: got %h expected %h", n, lock_ac, e_lac); end
            checks++; if ({mem_adr, mem_we} !== {e_adr, e_we}) begin errors++; $display("FAIL rnd_bus[%0d]: got %h/%b expected %h/%b", n, mem_adr, mem_we, e_adr, e_we); end
            if (e_we) begin
                checks++; if (mem_wdat !== e_dat) begin errors++; $display("FAIL rnd_dat[%0d]: got %h expected %h", n, mem_wdat, e_dat); end
            end
            unlock_en = '0;
            for (int i = 0; i < C; i++) begin
                c = 3'(i);
                if (e_mac[c]) begin
                    rd_req[c] = 1'b0; wr_req[c] = 1'b0;
                end else if (!rd_req[c] && !wr_req[c] && $urandom_range(0, 2) == 0) begin
                    r = int'($urandom_range(0, 2));
                    rd_req[c] = (r != 1); wr_req[c] = (r != 0);
                    rd_adr[c] = 16'($urandom); wr_adr[c] = 16'($urandom); wr_dat[c] = 16'($urandom);
                end
                if (e_lac[c]) begin
                    lock_en[c] = 1'b0;
                end else if (!lock_en[c]) begin
                    if ($urandom_range(0, 4) == 0) begin
                        lock_adr[c] = 4'($urandom_range(0, 3));
                        lock_en[c] = 1'b1;
                    end else if ($urandom_range(0, 2) == 0) begin
                        a = 4'($urandom_range(0, 3));
                        for (int k = 0; k < 4; k++)
                            if (m_held[4'(k)] && m_owner[4'(k)] == i && $urandom_range(0, 1) == 0) a = 4'(k);
                        lock_adr[c] = a;
                        unlock_en[c] = 1'b1;
                    end
                end
            end
        end
        clear_inputs();
        cycle();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_write();
        test_lock_contend();
        test_nonowner();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
